// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stage register: buffer state encoding
// and occupancy width.
package pipeline_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module pipe_stall_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/pipeline_stage_register.sv
// Two-entry (main + skid) pipeline stage with registered in_ready, flush,
// bubble zeroing of control payload and a saturating stall counter.
module pipeline_stage_register
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  state_t              state_p0, state_nxt;
  logic [DATA_W-1:0]   main_data_p0, skid_data_p0;
  logic [CTRL_W-1:0]   main_ctrl_p0, skid_ctrl_p0;
  logic                in_fire, out_fire;
  logic                load_main_in, load_main_skid, load_skid;

  // Handshake outputs decode from the state register only.
  assign in_ready  = (state_p0 != ST_FULL);
  assign out_valid = (state_p0 != ST_EMPTY);
  assign occupancy = state_p0;
  assign out_data  = main_data_p0;
  assign out_ctrl  = out_valid ? main_ctrl_p0 : '0;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_nxt      = state_p0;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      unique case (state_p0)
        ST_EMPTY: begin
          if (in_fire) begin
            state_nxt    = ST_BUSY;
            load_main_in = 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_fire && !out_fire) begin
            state_nxt = ST_FULL;
            load_skid = 1'b1;
          end else if (out_fire && !in_fire) begin
            state_nxt = ST_EMPTY;
          end else if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_nxt      = ST_BUSY;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Stage boundary: buffer entries and state update on the rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0     <= ST_EMPTY;
      main_data_p0 <= '0;
      main_ctrl_p0 <= '0;
      skid_data_p0 <= '0;
      skid_ctrl_p0 <= '0;
    end else begin
      state_p0 <= state_nxt;
      if (load_main_in) begin
        main_data_p0 <= in_data;
        main_ctrl_p0 <= in_ctrl;
      end else if (load_main_skid) begin
        main_data_p0 <= skid_data_p0;
        main_ctrl_p0 <= skid_ctrl_p0;
      end
      if (load_skid) begin
        skid_data_p0 <= in_data;
        skid_ctrl_p0 <= in_ctrl;
      end
    end
  end

  pipe_stall_counter #(
    .CNT_W(CNT_W)
  ) u_stall_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (out_valid & ~out_ready),
    .count(stall_cycles)
  );

endmodule

// File: doc/pipeline_stage_register.md
PIPELINE_STAGE_REGISTER -- requirements
Module: pipeline_stage_register

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the datapath payload (pc, ALU results, addresses).
REQ-002 SHALL have parameter CTRL_W, default 8: width of control payload (wren bits, mux selects), zeroed on bubble/flush.
REQ-003 SHALL have parameter CNT_W, default 16: width of stall-cycle counter.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  discard all held beats (branch mispredict/exception).
REQ-007 SHALL have port in_valid  input  1  upstream beat present.
REQ-008 SHALL have port in_ready  output  1  stage can accept a beat.
REQ-009 SHALL have port in_data  input  DATA_W  upstream datapath payload.
REQ-010 SHALL have port in_ctrl  input  CTRL_W  upstream control payload.
REQ-011 SHALL have port out_valid  output  1  downstream beat present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-013 SHALL have port out_data  output  DATA_W  held datapath payload.
REQ-014 SHALL have port out_ctrl  output  CTRL_W  held control payload, 0 when out_valid=0.
REQ-015 SHALL have port occupancy  output  2  number of held beats, 0..2.
REQ-016 SHALL have port stall_cycles  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-018 SHALL implement a 2-entry buffer (main, skid) with states EMPTY, BUSY, FULL; occupancy 0/1/2 respectively.
REQ-019 SHALL transition EMPTY -> BUSY on in_fire, loading main from in_data/in_ctrl.
REQ-020 SHALL, in BUSY: in_fire & !out_fire -> FULL (skid loaded); out_fire & !in_fire -> EMPTY; both -> BUSY with main reloaded from input; neither -> hold.
REQ-021 SHALL, in FULL: out_fire -> BUSY with main loaded from skid; else hold.
REQ-022 SHALL drive in_ready = (state != FULL), decoded from state registers only; no combinational path from out_ready or flush to in_ready.
REQ-023 SHALL drive out_valid = (state != EMPTY); out_data/out_ctrl from main entry.
REQ-024 SHALL force out_ctrl to 0 whenever out_valid=0 (bubble); out_data retains last main value.
REQ-025 SHALL preserve beat order; a beat accepted at edge N is presented on out_* after edge N (1-cycle latency) if main was empty or drained at edge N.
REQ-026 SHALL, on flush=1, go to EMPTY at the next edge regardless of state; any beat transferred by in_fire in the same cycle is discarded.
REQ-027 SHALL, on flush with out_fire in the same cycle, treat the out beat as delivered (downstream owns it).
REQ-028 SHALL increment stall_cycles when out_valid & !out_ready, saturating at 2^CNT_W-1; flush does not clear it.

Reset
REQ-029 SHALL, on reset=1 at a rising edge, set state EMPTY, main/skid data and ctrl to 0, stall_cycles to 0.
REQ-030 SHALL, during and after reset, output in_ready=1, out_valid=0, out_data=0, out_ctrl=0, occupancy=0.
REQ-031 SHALL give reset priority over flush and all handshakes, including mid-operation in FULL.

Structure
REQ-032 SHALL take the state encoding (EMPTY=0, BUSY=1, FULL=2) and occupancy width from shared package pipeline_pkg.
REQ-033 SHALL place the saturating counter in sub-module pipe_stall_counter (parameter CNT_W; ports clk, reset, inc, count).

Verification
REQ-034 SHALL test pass-through: out_ready=1, in_data 0x10,0x11,0x12 on consecutive cycles -> same values on out_data one cycle later, occupancy<=1, stall_cycles=0.
REQ-035 SHALL test backpressure: out_ready=0, send 0xA,0xB,0xC -> in_ready=0 after two accepts, 0xC held upstream, occupancy=2; release out_ready -> 0xA,0xB,0xC in order.
REQ-036 SHALL test flush in FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; flushed beats never appear.
REQ-037 SHALL test stall saturation with CNT_W=4: 20 stalled cycles -> stall_cycles=15.
REQ-038 SHALL test reset mid-operation: reset asserted in FULL -> all outputs to reset values next cycle; stall_cycles=0.
